// File: rtl/confreg.sv
// Memory-mapped configuration/peripheral registers: LEDs, switches, buttons, 7-seg value,
// scratch, free-running timer with compare, sticky status and an interrupt line.
`ifndef XLEN
`define XLEN 32
`endif

module confreg #(
  parameter int LED_W = 16,
  parameter int SW_W  = 8,
  parameter int BTN_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              conf_en,
  input  logic [3:0]        conf_wen,
  input  logic [`XLEN-1:0]  conf_addr,
  input  logic [`XLEN-1:0]  conf_wdata,
  output logic [`XLEN-1:0]  conf_rdata,
  output logic [LED_W-1:0]  led,
  output logic [31:0]       num,
  input  logic [SW_W-1:0]   switch,
  input  logic [BTN_W-1:0]  btn,
  output logic              irq
);

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      num_q, num_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      cmp_q, cmp_d;
  logic [BTN_W:0]   status_q, status_d;
  logic [BTN_W:0]   irq_en_q, irq_en_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic [BTN_W-1:0] btn_s1_q, btn_s2_q, btn_dly_q;

  logic             wr, rd;
  logic [5:0]       idx;
  logic [31:0]      bm;
  logic [BTN_W:0]   status_set, status_clr;
  logic             unused_addr;

  assign unused_addr = ^{conf_addr[`XLEN-1:8], conf_addr[1:0]};
  assign wr  = conf_en & (|conf_wen);
  assign rd  = conf_en & ~(|conf_wen);
  assign idx = conf_addr[7:2];
  assign bm  = {{8{conf_wen[3]}}, {8{conf_wen[2]}}, {8{conf_wen[1]}}, {8{conf_wen[0]}}};

  always_comb begin
    led_d      = led_q;
    num_d      = num_q;
    scratch_d  = scratch_q;
    timer_d    = timer_q + 32'd1;
    cmp_d      = cmp_q;
    irq_en_d   = irq_en_q;
    status_clr = '0;
    status_set = {btn_s2_q & ~btn_dly_q, timer_q == cmp_q};
    if (wr) begin
      case (idx)
        6'h00: led_d     = (led_q & ~bm[LED_W-1:0]) | (conf_wdata[LED_W-1:0] & bm[LED_W-1:0]);
        // Unwritten timer bytes keep the old value; the increment is skipped this cycle.
        6'h02: timer_d   = (timer_q & ~bm) | (conf_wdata[31:0] & bm);
        6'h03: num_d     = (num_q & ~bm) | (conf_wdata[31:0] & bm);
        6'h04: scratch_d = (scratch_q & ~bm) | (conf_wdata[31:0] & bm);
        6'h05: cmp_d     = (cmp_q & ~bm) | (conf_wdata[31:0] & bm);
        6'h06: status_clr = conf_wdata[BTN_W:0] & bm[BTN_W:0];
        6'h07: irq_en_d  = (irq_en_q & ~bm[BTN_W:0]) | (conf_wdata[BTN_W:0] & bm[BTN_W:0]);
        default: ;
      endcase
    end
    // Set beats a coincident write-1-to-clear.
    status_d = (status_q & ~status_clr) | status_set;
    irq_d    = |(status_d & irq_en_d);

    rdata_d = rdata_q;
    if (rd) begin
      case (idx)
        6'h00:   rdata_d = 32'(led_q);
        6'h01:   rdata_d = 32'(sw_s2_q);
        6'h02:   rdata_d = timer_q;
        6'h03:   rdata_d = num_q;
        6'h04:   rdata_d = scratch_q;
        6'h05:   rdata_d = cmp_q;
        6'h06:   rdata_d = 32'(status_q);
        6'h07:   rdata_d = 32'(irq_en_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q     <= '0;
      num_q     <= '0;
      scratch_q <= '0;
      timer_q   <= '0;
      cmp_q     <= '1;
      status_q  <= '0;
      irq_en_q  <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      btn_dly_q <= '0;
    end else begin
      led_q     <= led_d;
      num_q     <= num_d;
      scratch_q <= scratch_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      status_q  <= status_d;
      irq_en_q  <= irq_en_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      sw_s1_q   <= switch;
      sw_s2_q   <= sw_s1_q;
      btn_s1_q  <= btn;
      btn_s2_q  <= btn_s1_q;
      btn_dly_q <= btn_s2_q;
    end
  end

  assign conf_rdata = rdata_q;
  assign led        = led_q;
  assign num        = num_q;
  assign irq        = irq_q;

endmodule
